// File: rtl/punc_mem_responder.sv
// Memory-side responder for the PUnC request port: one request at a time, a
// fixed read/write latency, and a valid/ready response with debug access counters.
module punc_mem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [15:0]       rd_count_o,
  output logic [15:0]       wr_count_o
);

  localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         rd_count_q, rd_count_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                mem_we_s;
  logic                in_range_s;
  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

  assign in_range_s = (addr_q[ADDR_W-1:DEPTH_LOG2] == {(ADDR_W-DEPTH_LOG2){1'b0}});

  // Next-state and response datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          we_d        = req_we_i;
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          cnt_d       = req_we_i ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
          req_ready_d = 1'b0;
          state_d     = ST_BUSY;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          // Out-of-range requests complete with an error and touch nothing.
          if (!in_range_s) begin
            err_d   = 1'b1;
            rdata_d = {DATA_W{1'b0}};
          end else if (we_q) begin
            mem_we_s   = 1'b1;
            rdata_d    = wdata_q;
            wr_count_d = wr_count_q + 16'd1;
          end else begin
            rdata_d    = mem_q[addr_q[DEPTH_LOG2-1:0]];
            rd_count_d = rd_count_q + 16'd1;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
      end
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Storage array; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rd_count_o  = rd_count_q;
  assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_punc_mem_responder.sv
// Directed self-checking bench for punc_mem_responder (RD_LAT=2, WR_LAT=1).
module tb_punc_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [15:0] req_addr_i;
  logic [15:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [15:0] rd_count_o;
  logic [15:0] wr_count_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] got_data;
  logic        got_err;

  punc_mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .RD_LAT(2), .WR_LAT(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rd_count_o(rd_count_o), .wr_count_o(wr_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, verify exact latency and stall behaviour, then consume.
  task automatic transact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int lat, input int hold,
                          output logic [15:0] rdata, output logic err);
    @(negedge clk_i);
    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    rsp_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'bx;
    req_addr_i  = 16'hxxxx;
    req_wdata_i = 16'hxxxx;
    for (int i = 1; i < lat; i++) begin
      @(posedge clk_i);
      #1;
      chk("rsp_valid_early", {31'd0, rsp_valid_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    chk("rsp_valid_at_lat", {31'd0, rsp_valid_o}, 32'd1);
    chk("req_ready_resp", {31'd0, req_ready_o}, 32'd0);
    rdata = rsp_rdata_o;
    err   = rsp_err_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i);
      #1;
      chk("hold_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("hold_rdata", {16'd0, rsp_rdata_o}, {16'd0, rdata});
      chk("hold_ready", {31'd0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid_o}, 32'd0);
    chk("rsp_err_clear", {31'd0, rsp_err_o}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready_o}, 32'd1);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = 16'h0000;
    req_wdata_i = 16'h0000;
    rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata_o}, 32'd0);
    chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count_o}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count_o}, 32'd0);
    rst_i = 1'b0;

    // Write then read back 0x0005
    transact(1'b1, 16'h0005, 16'hBEEF, 1, 0, got_data, got_err);
    chk("t1_wr_echo", {16'd0, got_data}, 32'h0000BEEF);
    transact(1'b0, 16'h0005, 16'h0000, 2, 0, got_data, got_err);
    chk("t1_rd_data", {16'd0, got_data}, 32'h0000BEEF);
    chk("t1_rd_err", {31'd0, got_err}, 32'd0);
    chk("t1_rd_count", {16'd0, rd_count_o}, 32'd1);
    chk("t1_wr_count", {16'd0, wr_count_o}, 32'd1);

    // Top in-range address with a stalled response
    transact(1'b1, 16'h00FF, 16'h1234, 1, 5, got_data, got_err);
    chk("t2_wr_echo", {16'd0, got_data}, 32'h00001234);
    chk("t2_wr_count", {16'd0, wr_count_o}, 32'd2);

    // First out-of-range address
    transact(1'b0, 16'h0100, 16'h0000, 2, 0, got_data, got_err);
    chk("t3_err", {31'd0, got_err}, 32'd1);
    chk("t3_rdata", {16'd0, got_data}, 32'd0);
    chk("t3_rd_count", {16'd0, rd_count_o}, 32'd1);

    // Out-of-range write must not alias onto word 0
    transact(1'b1, 16'h0000, 16'h7777, 1, 0, got_data, got_err);
    transact(1'b1, 16'h0200, 16'hAAAA, 1, 0, got_data, got_err);
    chk("t4_err", {31'd0, got_err}, 32'd1);
    chk("t4_rdata", {16'd0, got_data}, 32'd0);
    chk("t4_wr_count", {16'd0, wr_count_o}, 32'd3);
    transact(1'b0, 16'h0000, 16'h0000, 2, 0, got_data, got_err);
    chk("t4_rd0", {16'd0, got_data}, 32'h00007777);
    transact(1'b0, 16'h00FF, 16'h0000, 2, 0, got_data, got_err);
    chk("t4_rdff", {16'd0, got_data}, 32'h00001234);
    chk("t4_rd_count", {16'd0, rd_count_o}, 32'd3);

    // Reset in the middle of a write abandons it
    transact(1'b1, 16'h0010, 16'h0123, 1, 0, got_data, got_err);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 16'h0010;
    req_wdata_i = 16'h5555;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    chk("t5_busy_ready", {31'd0, req_ready_o}, 32'd0);
    #1;
    rst_i = 1'b1;
    #1;
    chk("t5_rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("t5_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("t5_rst_rdata", {16'd0, rsp_rdata_o}, 32'd0);
    chk("t5_rst_wr_count", {16'd0, wr_count_o}, 32'd0);
    chk("t5_rst_rd_count", {16'd0, rd_count_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    transact(1'b0, 16'h0010, 16'h0000, 2, 0, got_data, got_err);
    chk("t5_old_data", {16'd0, got_data}, 32'h00000123);
    chk("t5_rd_count", {16'd0, rd_count_o}, 32'd1);

    // Write counter wraps
    @(negedge clk_i);
    force dut.wr_count_q = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    #1;
    chk("t6_preload", {16'd0, wr_count_o}, 32'h0000FFFF);
    transact(1'b1, 16'h0020, 16'h4242, 1, 0, got_data, got_err);
    chk("t6_wrap", {16'd0, wr_count_o}, 32'd0);
    chk("t6_rd_count", {16'd0, rd_count_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
